ball_ctl: RTL

- Game-logic stage directly upstream of the ball/pad renderer: owns ball position, velocity and scoring events.
- Advances the ball once per video frame on frame_tick.
- Bounces the ball off the top/bottom walls and both pad faces, and detects misses.
- Drives x_ball/y_ball to the renderer and point pulses to the score keeper.

---
 rtl/ball_ctl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ball_ctl.sv
// Game-logic stage ahead of the ball/pad renderer: ball position, velocity, wall/pad bounces and point pulses.
// Optional BALL_SPEEDUP_EN: every 4th pad hit raises the ball speed by one, saturating at 8.
module ball_ctl #(
  parameter int H_RES        = 1024,
  parameter int V_RES        = 768,
  parameter int BALL_SIZE    = 15,
  parameter int PAD_HEIGHT   = 145,
  parameter int PAD_WIDTH    = 15,
  parameter int X_PAD_LEFT   = 30,
  parameter int X_PAD_RIGHT  = 979,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic        point_left,
  output logic        point_right,
  output logic        in_play
);

  // state  | meaning
  // IDLE   | ball centred, waiting for start
  // SERVE  | ball centred, counting SERVE_FRAMES frame ticks
  // PLAY   | ball moving, bounce/miss evaluated each frame tick
  // SCORED | ball frozen at the exit edge until the next frame tick
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} state_t;

  localparam int          CW        = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] X_CENTRE  = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] Y_CENTRE  = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] Y_BOTTOM  = 11'(V_RES - 1 - BALL_SIZE);
  localparam logic [10:0] X_RIGHT   = 11'(H_RES - 1 - BALL_SIZE);
  localparam logic [10:0] X_LBOUNCE = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
  localparam logic [10:0] X_RBOUNCE = 11'(X_PAD_RIGHT - 1 - BALL_SIZE);
  localparam logic [11:0] BS        = 12'(BALL_SIZE);
  localparam logic [11:0] PH        = 12'(PAD_HEIGHT);
  localparam logic [11:0] X_LFACE   = 12'(X_PAD_LEFT + PAD_WIDTH);
  localparam logic [11:0] X_RFACE   = 12'(X_PAD_RIGHT);
  localparam logic [11:0] Y_LIMIT   = 12'(V_RES - 1);
  localparam logic [11:0] X_LIMIT   = 12'(H_RES - 1);

  state_t          state, state_nxt;
  logic [10:0]     x_nxt, y_nxt;
  logic            dx, dx_nxt, dy, dy_nxt;
  logic            dx_serve, dx_serve_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            point_left_nxt, point_right_nxt;
  logic [3:0]      speed;

  logic [11:0] x12, y12, spd12, pl12, pr12;
  logic        ov_l, ov_r, pad_l_hit, pad_r_hit, miss_l, miss_r, top_hit, bot_hit;

  // All geometry compares are widened to 12 bits so sums never wrap.
  always_comb begin
    x12       = {1'b0, x_ball};
    y12       = {1'b0, y_ball};
    spd12     = {8'd0, speed};
    pl12      = {2'b0, y_pad_left};
    pr12      = {2'b0, y_pad_right};
    ov_l      = (y12 + BS >= pl12) && (y12 <= pl12 + PH);
    ov_r      = (y12 + BS >= pr12) && (y12 <= pr12 + PH);
    pad_l_hit = !dx && (x12 >= X_LFACE) && (x12 - spd12 <= X_LFACE) && ov_l;
    pad_r_hit = dx && (x12 + BS < X_RFACE) && (x12 + BS + spd12 >= X_RFACE) && ov_r;
    miss_l    = !dx && (x12 <= spd12);
    miss_r    = dx && (x12 + BS + spd12 >= X_LIMIT);
    top_hit   = !dy && (y12 <= spd12);
    bot_hit   = dy && (y12 + BS + spd12 >= Y_LIMIT);
  end

  always_comb begin
    state_nxt       = state;
    x_nxt           = x_ball;
    y_nxt           = y_ball;
    dx_nxt          = dx;
    dy_nxt          = dy;
    dx_serve_nxt    = dx_serve;
    cnt_nxt         = cnt;
    point_left_nxt  = 1'b0;
    point_right_nxt = 1'b0;
    case (state)
      IDLE: begin
        x_nxt = X_CENTRE;
        y_nxt = Y_CENTRE;
        if (start) begin
          cnt_nxt   = CW'(SERVE_FRAMES - 1);
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        x_nxt = X_CENTRE;
        y_nxt = Y_CENTRE;
        if (frame_tick) begin
          if (cnt == '0) begin
            dx_nxt    = dx_serve;
            dy_nxt    = 1'b0;
            state_nxt = PLAY;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (top_hit) begin
            y_nxt  = '0;
            dy_nxt = 1'b1;
          end else if (bot_hit) begin
            y_nxt  = Y_BOTTOM;
            dy_nxt = 1'b0;
          end else if (dy) begin
            y_nxt = y_ball + {7'd0, speed};
          end else begin
            y_nxt = y_ball - {7'd0, speed};
          end
          // Pad contact outranks a miss evaluated in the same tick.
          if (pad_l_hit) begin
            x_nxt  = X_LBOUNCE;
            dx_nxt = 1'b1;
          end else if (pad_r_hit) begin
            x_nxt  = X_RBOUNCE;
            dx_nxt = 1'b0;
          end else if (miss_l) begin
            x_nxt           = '0;
            point_right_nxt = 1'b1;
            dx_serve_nxt    = 1'b0;
            state_nxt       = SCORED;
          end else if (miss_r) begin
            x_nxt          = X_RIGHT;
            point_left_nxt = 1'b1;
            dx_serve_nxt   = 1'b1;
            state_nxt      = SCORED;
          end else if (dx) begin
            x_nxt = x_ball + {7'd0, speed};
          end else begin
            x_nxt = x_ball - {7'd0, speed};
          end
        end
      end
      SCORED: begin
        if (frame_tick) begin
          x_nxt     = X_CENTRE;
          y_nxt     = Y_CENTRE;
          dy_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_ball      <= X_CENTRE;
      y_ball      <= Y_CENTRE;
      dx          <= 1'b1;
      dy          <= 1'b0;
      dx_serve    <= 1'b1;
      cnt         <= '0;
      point_left  <= 1'b0;
      point_right <= 1'b0;
    end else begin
      state       <= state_nxt;
      x_ball      <= x_nxt;
      y_ball      <= y_nxt;
      dx          <= dx_nxt;
      dy          <= dy_nxt;
      dx_serve    <= dx_serve_nxt;
      cnt         <= cnt_nxt;
      point_left  <= point_left_nxt;
      point_right <= point_right_nxt;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [3:0] speed_nxt;
  logic [2:0] hit_cnt, hit_cnt_nxt;

  always_comb begin
    speed_nxt   = speed;
    hit_cnt_nxt = hit_cnt;
    if (state == IDLE && start) begin
      speed_nxt   = 4'(BALL_SPEED);
      hit_cnt_nxt = '0;
    end else if (state == PLAY && frame_tick && (pad_l_hit || pad_r_hit)) begin
      hit_cnt_nxt = hit_cnt + 3'd1;
      if (hit_cnt[1:0] == 2'd3 && speed < 4'd8) speed_nxt = speed + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed   <= 4'(BALL_SPEED);
      hit_cnt <= '0;
    end else begin
      speed   <= speed_nxt;
      hit_cnt <= hit_cnt_nxt;
    end
  end
`else
  assign speed = 4'(BALL_SPEED);
`endif

  assign in_play = (state == SERVE) || (state == PLAY);

endmodule
